// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST: FSM state encoding and default data pattern.
// Optional feature macro: RAM_BIST_INV_PASS_EN adds the inverted-data second pass states.
package ram_bist_pkg;

   localparam logic [31:0] RAM_BIST_PATTERN = 32'hA5A5_A5A5;

   // state  | meaning
   // IDLE   | waiting for start, outputs quiet
   // WR     | writing expected(a) to every address
   // RD     | reading every address, checking the previous read
   // DRAIN  | checking the last read of RD
   // WRI    | writing ~expected(a) (inverted pass only)
   // RDI    | reading back inverted data (inverted pass only)
   // DRAINI | checking the last read of RDI (inverted pass only)
   // FIN    | one-cycle done pulse, result valid
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR    = 3'd1,
      ST_RD    = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FIN   = 3'd4
`ifdef RAM_BIST_INV_PASS_EN
      ,
      ST_WRI    = 3'd5,
      ST_RDI    = 3'd6,
      ST_DRAINI = 3'd7
`endif
   } state_e;

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker: remembers the address/expected data presented last cycle,
// compares it against the RAM output, and captures the pass/fail result.
module ram_bist_cmp #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              chk_en,
   input  logic [ADDR_W-1:0] adr,
   input  logic [DATA_W-1:0] exp_data,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic              fin_ok,
   output logic              mismatch,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_adr
);

   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] exp_q;
   logic              vld_q;

   // RAM output belongs to the address presented one cycle earlier
   always_comb begin
      mismatch = vld_q && (mem_dout != exp_q);
   end

   // Pipeline the read address/expected value and capture the test result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         adr_q    <= '0;
         exp_q    <= '0;
         vld_q    <= 1'b0;
         pass     <= 1'b0;
         fail_adr <= '0;
      end else begin
         adr_q <= adr;
         exp_q <= exp_data;
         // a mismatch ends the test, so the read issued alongside it is never checked
         vld_q <= chk_en && !mismatch;
         if (clear) begin
            pass     <= 1'b0;
            fail_adr <= '0;
         end else if (mismatch) begin
            pass     <= 1'b0;
            fail_adr <= adr_q;
         end else if (fin_ok) begin
            pass     <= 1'b1;
            fail_adr <= '0;
         end
      end
   end

endmodule

// File: rtl/ram_bist.sv
// March-style RAM BIST: write expected(a)=PATTERN^a to all addresses, read back
// and check, report first failing address. Synchronous active-low reset.
// Optional macro RAM_BIST_INV_PASS_EN appends a second pass with inverted data.
module ram_bist
   import ram_bist_pkg::*;
#(
   parameter int          ADDR_W  = 6,
   parameter int          DATA_W  = 32,
   parameter logic [31:0] PATTERN = RAM_BIST_PATTERN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_adr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam logic [DATA_W-1:0] PAT      = DATA_W'(PATTERN);
   localparam logic [ADDR_W-1:0] ADR_LAST = {ADDR_W{1'b1}};

   state_e            state;
   logic [ADDR_W-1:0] adr;
   logic              wr_ph;
   logic              rd_ph;
   logic              inv_ph;
   logic              adr_last;
   logic              mismatch;
   logic              fin_ok;
   logic              clear;
   logic [DATA_W-1:0] exp_cur;

   // Phase decode and expected data for the address currently on the bus
   always_comb begin
      wr_ph  = (state == ST_WR);
      rd_ph  = (state == ST_RD);
      inv_ph = 1'b0;
      fin_ok = (state == ST_DRAIN) && !mismatch;
`ifdef RAM_BIST_INV_PASS_EN
      wr_ph  = wr_ph || (state == ST_WRI);
      rd_ph  = rd_ph || (state == ST_RDI);
      inv_ph = (state == ST_WRI) || (state == ST_RDI) || (state == ST_DRAINI);
      fin_ok = (state == ST_DRAINI) && !mismatch;
`endif
      adr_last = (adr == ADR_LAST);
      clear    = (state == ST_IDLE) && start;
      exp_cur  = PAT ^ DATA_W'(adr);
      if (inv_ph) begin
         exp_cur = ~exp_cur;
      end
   end

   // RAM bus and status outputs, all quiet outside the active phases
   always_comb begin
      busy    = (state != ST_IDLE) && (state != ST_FIN);
      done    = (state == ST_FIN);
      mem_we  = wr_ph;
      mem_adr = (wr_ph || rd_ph) ? adr : '0;
      mem_din = wr_ph ? exp_cur : '0;
   end

   // Sequencer: phase state plus address counter that restarts at each phase
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         adr   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               adr <= '0;
               if (start) begin
                  state <= ST_WR;
               end
            end
            ST_WR: begin
               if (adr_last) begin
                  state <= ST_RD;
                  adr   <= '0;
               end else begin
                  adr <= adr + 1'b1;
               end
            end
            ST_RD: begin
               if (mismatch) begin
                  state <= ST_FIN;
                  adr   <= '0;
               end else if (adr_last) begin
                  state <= ST_DRAIN;
                  adr   <= '0;
               end else begin
                  adr <= adr + 1'b1;
               end
            end
            ST_DRAIN: begin
               adr <= '0;
`ifdef RAM_BIST_INV_PASS_EN
               state <= mismatch ? ST_FIN : ST_WRI;
`else
               state <= ST_FIN;
`endif
            end
`ifdef RAM_BIST_INV_PASS_EN
            ST_WRI: begin
               if (adr_last) begin
                  state <= ST_RDI;
                  adr   <= '0;
               end else begin
                  adr <= adr + 1'b1;
               end
            end
            ST_RDI: begin
               if (mismatch) begin
                  state <= ST_FIN;
                  adr   <= '0;
               end else if (adr_last) begin
                  state <= ST_DRAINI;
                  adr   <= '0;
               end else begin
                  adr <= adr + 1'b1;
               end
            end
            ST_DRAINI: begin
               state <= ST_FIN;
               adr   <= '0;
            end
`endif
            ST_FIN: begin
               state <= ST_IDLE;
               adr   <= '0;
            end
            default: begin
               state <= ST_IDLE;
               adr   <= '0;
            end
         endcase
      end
   end

   ram_bist_cmp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_cmp (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .chk_en   (rd_ph),
      .adr      (adr),
      .exp_data (exp_cur),
      .mem_dout (mem_dout),
      .fin_ok   (fin_ok),
      .mismatch (mismatch),
      .pass     (pass),
      .fail_adr (fail_adr)
   );

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with a synchronous-read RAM model and read-fault injection.
// Honours RAM_BIST_INV_PASS_EN to select expected timing/results of the inverted pass.
module tb_ram_bist;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

`ifdef RAM_BIST_INV_PASS_EN
   localparam int DONE_OK = 259;
`else
   localparam int DONE_OK = 130;
`endif

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ADDR_W-1:0] fail_adr;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_adr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   logic [DATA_W-1:0] ram_mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_q;
   logic [ADDR_W-1:0] rd_adr_q;
   logic              flt_on;
   logic [ADDR_W-1:0] flt_adr;
   logic [DATA_W-1:0] flt_and;
   logic [DATA_W-1:0] flt_xor;

   int n_assert;
   int n_fail;
   int cyc;

   ram_bist #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .PATTERN (32'hA5A5_A5A5)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .fail_adr (fail_adr),
      .mem_we   (mem_we),
      .mem_adr  (mem_adr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-port RAM, read data registered one cycle after the address
   always @(posedge clk) begin
      if (mem_we) ram_mem[mem_adr] <= mem_din;
      rd_q     <= ram_mem[mem_adr];
      rd_adr_q <= mem_adr;
   end

   assign mem_dout = (flt_on && rd_adr_q == flt_adr) ? ((rd_q & flt_and) ^ flt_xor) : rd_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_assert++;
      assert (got === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
      end
   endtask

   task automatic set_fault(input logic on, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] andm, input logic [DATA_W-1:0] xorm);
      flt_on  = on;
      flt_adr = a;
      flt_and = andm;
      flt_xor = xorm;
   endtask

   // pulse start, run until done (bounded), then check result and hold behaviour
   task automatic run_test(input string tag, input int exp_done, input logic exp_pass,
                           input logic [ADDR_W-1:0] exp_fa, input int restart_cyc);
      int done_cyc;
      done_cyc = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      check({tag, "_pass_clr"}, {31'd0, pass}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      while (done_cyc == 0 && cyc < 600) begin
         if (cyc == 6) begin
            check({tag, "_we5"}, {31'd0, mem_we}, 32'd1);
            check({tag, "_adr5"}, {26'd0, mem_adr}, 32'd5);
            check({tag, "_din5"}, mem_din, 32'hA5A5_A5A0);
         end
         if (done) begin
            done_cyc = cyc;
         end else begin
            start = (cyc == restart_cyc);
            @(posedge clk); #1;
            cyc++;
         end
      end
      start = 1'b0;
      check({tag, "_done_cyc"}, done_cyc, exp_done);
      check({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_pass});
      check({tag, "_fail_adr"}, {26'd0, fail_adr}, {26'd0, exp_fa});
      check({tag, "_busy_fin"}, {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_pass_hold"}, {31'd0, pass}, {31'd0, exp_pass});
      check({tag, "_fa_hold"}, {26'd0, fail_adr}, {26'd0, exp_fa});
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      set_fault(1'b0, '0, '1, '0);

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_pass", {31'd0, pass}, 32'd0);
      check("rst_fail_adr", {26'd0, fail_adr}, 32'd0);
      check("rst_we", {31'd0, mem_we}, 32'd0);
      check("rst_adr", {26'd0, mem_adr}, 32'd0);
      check("rst_din", mem_din, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // fault-free RAM
      run_test("clean", DONE_OK, 1'b1, 6'd0, 0);

      // bit 0 inverted when reading address 17: caught in the first read pass
      set_fault(1'b1, 6'd17, '1, 32'h1);
      run_test("flt17", 84, 1'b0, 6'd17, 0);

      // fault at last address: only visible in DRAIN
      set_fault(1'b1, 6'd63, '1, 32'h1);
      run_test("flt63", 130, 1'b0, 6'd63, 0);
      set_fault(1'b0, '0, '1, '0);

      // start re-pulsed mid-test is ignored
      run_test("restart", DONE_OK, 1'b1, 6'd0, 40);

      // reset during the write phase aborts with no done
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (cyc < 40) begin
         check("abort_no_done", {31'd0, done}, 32'd0);
         @(posedge clk); #1;
         cyc++;
      end
      check("abort_we_before", {31'd0, mem_we}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort_we", {31'd0, mem_we}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_pass", {31'd0, pass}, 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
         check("abort_done", {31'd0, done}, 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_idle_done", {31'd0, done}, 32'd0);
      run_test("rerun", DONE_OK, 1'b1, 6'd0, 0);

      // bit 0 stuck-at-0 at address 5: expected bit 0 is 0 in the true pass, 1 in the inverted pass
      set_fault(1'b1, 6'd5, 32'hFFFF_FFFE, '0);
`ifdef RAM_BIST_INV_PASS_EN
      run_test("sa0_5", 201, 1'b0, 6'd5, 0);
`else
      run_test("sa0_5", 130, 1'b1, 6'd0, 0);
`endif
      set_fault(1'b0, '0, '1, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM address width; N = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 SHALL have parameter PATTERN, default 32'hA5A5_A5A5, base data pattern, truncated or zero-extended to DATA_W.
REQ-004 SHALL have ports, clock and reset first; one clock; reset is synchronous and active-low:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin test; sampled in IDLE only.
- busy  output  1  test in progress.
- done  output  1  one-cycle pulse at test end.
- pass  output  1  result; held until next accepted start.
- fail_adr  output  ADDR_W  first failing address; held until next accepted start.
- mem_we  output  1  RAM write enable.
- mem_adr  output  ADDR_W  RAM address.
- mem_din  output  DATA_W  RAM write data.
- mem_dout  input  DATA_W  RAM read data, valid the cycle after mem_adr is presented with mem_we=0.

Function
REQ-005 SHALL implement states IDLE, WR, RD, DRAIN, FIN, with transitions:
- IDLE->WR on start=1.
- WR->RD after address N-1.
- RD->DRAIN after address N-1.
- DRAIN->FIN.
- FIN->IDLE.
REQ-006 SHALL define expected(a) = PATTERN XOR zero-extended a.
REQ-007 In WR, SHALL drive mem_we=1, mem_adr=0..N-1 ascending one per cycle, mem_din=expected(mem_adr).
REQ-008 In RD, SHALL drive mem_we=0, mem_adr=0..N-1 ascending one per cycle.
REQ-009 SHALL compare mem_dout against the expected value of the previous cycle's address:
- in every RD cycle except the first;
- in DRAIN, for address N-1.
REQ-010 On first mismatch, SHALL capture fail_adr=compared address, clear pass, and enter FIN next cycle, skipping the remaining addresses.
REQ-011 If no mismatch occurs, SHALL set pass=1 and fail_adr=0 on entering FIN.
REQ-012 SHALL assert busy in WR, RD and DRAIN, and done only in FIN.
REQ-013 Timing: start sampled at edge 0 -> WR cycles 1..N, RD cycles N+1..2N, DRAIN cycle 2N+1, done in cycle 2N+2 (130 for ADDR_W=6).
REQ-014 SHALL ignore start while busy or in FIN; start held high in IDLE after FIN restarts the test.
REQ-015 Outside WR, SHALL drive mem_we=0 and mem_din=0; mem_adr SHALL be 0 in IDLE and FIN.
REQ-016 Address counter SHALL not wrap within a phase and SHALL reset to 0 at each phase entry.

Reset
REQ-017 With rst_n=0 at a rising edge, SHALL enter IDLE with busy=0, done=0, pass=0, fail_adr=0, mem_we=0, mem_adr=0, mem_din=0.
REQ-018 Reset mid-test SHALL abort without done; the next start SHALL run a full test.

Configuration
REQ-019 Macro RAM_BIST_INV_PASS_EN SHALL control an inverted-data second pass.
REQ-020 With RAM_BIST_INV_PASS_EN defined:
- DRAIN SHALL proceed to WRI, RDI, DRAINI, then FIN.
- WRI, RDI and DRAINI SHALL behave as WR, RD and DRAIN with data ~expected(a).
- done SHALL occur in cycle 4N+3 (259 for ADDR_W=6).
- A mismatch in either pass SHALL go to FIN per REQ-010.
REQ-021 Without RAM_BIST_INV_PASS_EN, WRI, RDI and DRAINI SHALL not exist and behaviour SHALL be per REQ-005..REQ-016.

Structure
REQ-022 Package ram_bist_pkg SHALL hold the state enum and the default PATTERN constant.
REQ-023 Sub-module ram_bist_cmp SHALL hold:
- the one-cycle delayed address and expected-data registers;
- the mismatch compare;
- the fail_adr/pass capture.

Verification
REQ-024 Bench SHALL connect the existing parameterised ram (ADDR_W=6, DATA_W=32) to the mem_* ports.
REQ-025 Fault-free RAM, start pulse at cycle 0 -> 64 writes with mem_din(5)=32'hA5A5_A5A0; done in cycle 130, pass=1, fail_adr=0.
REQ-026 Read data bit 0 forced inverted at address 17 -> done in cycle 84, pass=0, fail_adr=17.
REQ-027 Read data fault at address 63 -> mismatch detected in DRAIN; done in cycle 130, pass=0, fail_adr=63.
REQ-028 start re-pulsed at cycle 40 -> ignored, done still in cycle 130.
REQ-029 rst_n low at cycle 40 -> mem_we=0 and busy=0 from that edge with no done; new start -> pass=1 after 130 cycles.
REQ-030 With RAM_BIST_INV_PASS_EN, fault-free RAM -> done in cycle 259, pass=1.
REQ-031 With RAM_BIST_INV_PASS_EN, bit 0 stuck-at-0 at address 5 -> fail_adr=5 reported from the pass whose expected bit 0 is 1.
